// File: rtl/alba_pkg.sv
// Shared encodings for the albaCore control unit: opcodes, ALU selects,
// controller states and fault codes.
package alba_pkg;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_SHL     = 4'd5;
  localparam logic [3:0] OP_SHR     = 4'd6;
  localparam logic [3:0] OP_MOV     = 4'd7;
  localparam logic [3:0] OP_LD      = 4'd8;
  localparam logic [3:0] OP_ST      = 4'd9;
  localparam logic [3:0] OP_BZ      = 4'd10;
  localparam logic [3:0] OP_BN      = 4'd11;
  localparam logic [3:0] OP_J       = 4'd12;
  localparam logic [3:0] OP_JR      = 4'd13;
  localparam logic [3:0] OP_ILLEGAL = 4'd14;
  localparam logic [3:0] OP_HALT    = 4'd15;

  // ALU selects 0-7 are the plain ALU ops and equal the opcode.
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_LD    = 4'd8;
  localparam logic [3:0] ALU_ST    = 4'd9;
  localparam logic [3:0] ALU_PCINC = 4'd10;
  localparam logic [3:0] ALU_BR    = 4'd11;
  localparam logic [3:0] ALU_JMP   = 4'd12;
  localparam logic [3:0] ALU_JR    = 4'd13;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_BUS     = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_ADDR,
    ST_MEM,
    ST_BRANCH,
    ST_PCINC,
    ST_HALT
  } state_t;

  function automatic logic is_bus_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/alba_decode.sv
// Combinational datapath control decode: maps controller state, opcode,
// ALU flags and the memory ack onto the ALU select and write strobes.
module alba_decode
  import alba_pkg::*;
(
  input  state_t     i_state,
  input  logic [3:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_neg,
  input  logic       i_mem_ack,
  output logic [3:0] o_alu_op,
  output logic       o_rf_we,
  output logic       o_wd_sel,
  output logic       o_pc_we,
  output logic       o_addr_sel,
  output logic       o_mem_we
);

  logic w_is_st;
  assign w_is_st = (i_opcode == OP_ST);

  always_comb begin
    o_alu_op   = ALU_ADD;
    o_rf_we    = 1'b0;
    o_wd_sel   = 1'b0;
    o_pc_we    = 1'b0;
    o_addr_sel = 1'b0;
    o_mem_we   = 1'b0;
    case (i_state)
      ST_EXEC: begin
        o_alu_op = i_opcode;
        o_rf_we  = 1'b1;
      end
      ST_ADDR: o_alu_op = w_is_st ? ALU_ST : ALU_LD;
      ST_MEM: begin
        // A load writes back on the ack cycle itself, straight from mem_rdata.
        o_alu_op   = w_is_st ? ALU_ST : ALU_LD;
        o_addr_sel = 1'b1;
        o_mem_we   = w_is_st;
        if (!w_is_st && i_mem_ack) begin
          o_rf_we  = 1'b1;
          o_wd_sel = 1'b1;
        end
      end
      ST_BRANCH: begin
        o_pc_we = 1'b1;
        case (i_opcode)
          OP_BZ:   o_alu_op = i_zero ? ALU_BR : ALU_PCINC;
          OP_BN:   o_alu_op = i_neg ? ALU_BR : ALU_PCINC;
          OP_J:    o_alu_op = ALU_JMP;
          default: o_alu_op = ALU_JR;
        endcase
      end
      ST_PCINC: begin
        o_alu_op = ALU_PCINC;
        o_pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alba_ctrl.sv
// albaCore multi-cycle controller: FSM, instruction register and bus handshake.
// Optional bus-timeout fault is built when ALBA_BUS_TIMEOUT_EN is defined.
module alba_ctrl
  import alba_pkg::*;
`ifdef ALBA_BUS_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 16
)
`endif
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_run,
  input  logic [15:0] i_mem_rdata,
  input  logic        i_mem_ack,
  input  logic        i_neg,
  input  logic        i_zero,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic        o_addr_sel,
  output logic [15:0] o_ir,
  output logic [3:0]  o_alu_op,
  output logic        o_rf_we,
  output logic        o_wd_sel,
  output logic        o_pc_we,
  output logic        o_halted,
  output logic [1:0]  o_fault
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ir;
  logic [1:0]  r_fault;
  logic [3:0]  w_opcode;
  logic        w_timeout;

  assign w_opcode = r_ir[15:12];

`ifdef ALBA_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts consecutive un-acked bus cycles; any state change restarts it.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_mem_ack || !is_bus_state(r_state) || (w_next_state != r_state))
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_timeout = is_bus_state(r_state) && !i_mem_ack &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_fault <= FAULT_NONE;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH && i_mem_ack)
        r_ir <= i_mem_rdata;
      if (r_state == ST_DECODE && w_opcode == OP_ILLEGAL)
        r_fault <= FAULT_ILLEGAL;
      if (w_timeout)
        r_fault <= FAULT_BUS;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_run) w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (i_mem_ack)      w_next_state = ST_DECODE;
        else if (w_timeout) w_next_state = ST_HALT;
      end
      ST_DECODE: begin
        case (w_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_XOR, OP_SHL, OP_SHR, OP_MOV: w_next_state = ST_EXEC;
          OP_LD, OP_ST:                   w_next_state = ST_ADDR;
          OP_BZ, OP_BN, OP_J, OP_JR:      w_next_state = ST_BRANCH;
          default:                        w_next_state = ST_HALT;
        endcase
      end
      ST_EXEC: w_next_state = ST_PCINC;
      ST_ADDR: w_next_state = ST_MEM;
      ST_MEM: begin
        if (i_mem_ack)      w_next_state = ST_PCINC;
        else if (w_timeout) w_next_state = ST_HALT;
      end
      ST_BRANCH, ST_PCINC: w_next_state = ST_FETCH;
      ST_HALT:             w_next_state = ST_HALT;
      default:             w_next_state = ST_IDLE;
    endcase
  end

  alba_decode u_decode (
    .i_state    (r_state),
    .i_opcode   (w_opcode),
    .i_zero     (i_zero),
    .i_neg      (i_neg),
    .i_mem_ack  (i_mem_ack),
    .o_alu_op   (o_alu_op),
    .o_rf_we    (o_rf_we),
    .o_wd_sel   (o_wd_sel),
    .o_pc_we    (o_pc_we),
    .o_addr_sel (o_addr_sel),
    .o_mem_we   (o_mem_we)
  );

  assign o_mem_req = is_bus_state(r_state);
  assign o_ir      = r_ir;
  assign o_halted  = (r_state == ST_HALT);
  assign o_fault   = r_fault;

endmodule

// File: tb/tb_alba_ctrl.sv
// Self-checking bench for alba_ctrl: a per-cycle scoreboard of expected outputs
// built from the instruction stream. Timeout cases need ALBA_BUS_TIMEOUT_EN.
module tb_alba_ctrl;

  localparam int VW      = 29;
  localparam int TIMEOUT = 16;

  typedef struct {
    string         tag;
    logic          rst;
    logic          run;
    logic          ack;
    logic [15:0]   rdata;
    logic          zero;
    logic          neg;
    logic [VW-1:0] exp;
  } cyc_t;

  logic        i_clk;
  logic        i_reset;
  logic        i_run;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        i_neg;
  logic        i_zero;
  logic        o_mem_req;
  logic        o_mem_we;
  logic        o_addr_sel;
  logic [15:0] o_ir;
  logic [3:0]  o_alu_op;
  logic        o_rf_we;
  logic        o_wd_sel;
  logic        o_pc_we;
  logic        o_halted;
  logic [1:0]  o_fault;

  cyc_t        sbQ[$];
  logic [15:0] expIr;
  int          errorCount = 0;
  int          checkCount = 0;

  alba_ctrl dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_run       (i_run),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ack   (i_mem_ack),
    .i_neg       (i_neg),
    .i_zero      (i_zero),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_addr_sel  (o_addr_sel),
    .o_ir        (o_ir),
    .o_alu_op    (o_alu_op),
    .o_rf_we     (o_rf_we),
    .o_wd_sel    (o_wd_sel),
    .o_pc_we     (o_pc_we),
    .o_halted    (o_halted),
    .o_fault     (o_fault)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Expected output vector: {ir, req, we, addr_sel, alu_op, rf_we, wd_sel, pc_we, halted, fault}
  function automatic logic [VW-1:0] mkExp(input logic [15:0] ir, input logic req, input logic we,
                                          input logic asel, input logic [3:0] alu, input logic rfwe,
                                          input logic wdsel, input logic pcwe, input logic halted,
                                          input logic [1:0] fault);
    return {ir, req, we, asel, alu, rfwe, wdsel, pcwe, halted, fault};
  endfunction

  function automatic logic rnd1();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic checkOutput(input string tag, input logic [VW-1:0] actual, input logic [VW-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic pushCyc(input string tag, input logic rst, input logic run, input logic ack,
                         input logic [15:0] rdata, input logic z, input logic n, input logic [VW-1:0] exp);
    cyc_t c;
    c.tag = tag; c.rst = rst; c.run = run; c.ack = ack;
    c.rdata = rdata; c.zero = z; c.neg = n; c.exp = exp;
    sbQ.push_back(c);
  endtask

  task automatic pushIdle(input logic run, input logic ack);
    pushCyc("idle", 1'b0, run, ack, 16'($urandom), rnd1(), rnd1(),
            mkExp(expIr, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
  endtask

  task automatic pushHalt(input int cnt, input logic [1:0] f);
    for (int k = 0; k < cnt; k++)
      pushCyc("halt", 1'b0, rnd1(), 1'b0, 16'($urandom), rnd1(), rnd1(),
              mkExp(expIr, 0, 0, 0, 4'd0, 0, 0, 0, 1, f));
  endtask

  // Queue one whole instruction: fetch with wf wait cycles, then its execution cycles.
  task automatic applyStimulus(input logic [15:0] instr, input int wf, input int wm,
                               input logic z, input logic n);
    logic [3:0] op;
    logic       isSt;
    logic [3:0] alu;
    op = instr[15:12];
    for (int k = 0; k < wf; k++)
      pushCyc("fetchWait", 1'b0, rnd1(), 1'b0, 16'($urandom), rnd1(), rnd1(),
              mkExp(expIr, 1, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
    pushCyc("fetchAck", 1'b0, rnd1(), 1'b1, instr, rnd1(), rnd1(),
            mkExp(expIr, 1, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
    expIr = instr;
    pushCyc("decode", 1'b0, rnd1(), 1'b0, 16'h0, rnd1(), rnd1(),
            mkExp(expIr, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
    if (op < 4'd8) begin
      pushCyc("exec", 1'b0, rnd1(), 1'b0, 16'h0, rnd1(), rnd1(),
              mkExp(expIr, 0, 0, 0, op, 1, 0, 0, 0, 2'd0));
      pushCyc("pcinc", 1'b0, rnd1(), 1'b0, 16'h0, rnd1(), rnd1(),
              mkExp(expIr, 0, 0, 0, 4'd10, 0, 0, 1, 0, 2'd0));
    end else if (op == 4'd8 || op == 4'd9) begin
      isSt = (op == 4'd9);
      alu  = isSt ? 4'd9 : 4'd8;
      pushCyc("addr", 1'b0, rnd1(), 1'b0, 16'h0, rnd1(), rnd1(),
              mkExp(expIr, 0, 0, 0, alu, 0, 0, 0, 0, 2'd0));
      for (int k = 0; k < wm; k++)
        pushCyc("memWait", 1'b0, rnd1(), 1'b0, 16'($urandom), rnd1(), rnd1(),
                mkExp(expIr, 1, isSt, 1, alu, 0, 0, 0, 0, 2'd0));
      pushCyc("memAck", 1'b0, rnd1(), 1'b1, 16'hBEEF, rnd1(), rnd1(),
              mkExp(expIr, 1, isSt, 1, alu, !isSt, !isSt, 0, 0, 2'd0));
      pushCyc("pcinc", 1'b0, rnd1(), 1'b0, 16'h0, rnd1(), rnd1(),
              mkExp(expIr, 0, 0, 0, 4'd10, 0, 0, 1, 0, 2'd0));
    end else if (op <= 4'd13) begin
      case (op)
        4'd10:   alu = z ? 4'd11 : 4'd10;
        4'd11:   alu = n ? 4'd11 : 4'd10;
        4'd12:   alu = 4'd12;
        default: alu = 4'd13;
      endcase
      pushCyc("branch", 1'b0, rnd1(), 1'b0, 16'h0, z, n,
              mkExp(expIr, 0, 0, 0, alu, 0, 0, 1, 0, 2'd0));
    end
  endtask

  task automatic runScoreboard();
    cyc_t c;
    int   idx;
    idx = 0;
    while (sbQ.size() > 0) begin
      c = sbQ.pop_front();
      @(negedge i_clk);
      i_reset     = c.rst;
      i_run       = c.run;
      i_mem_ack   = c.ack;
      i_mem_rdata = c.rdata;
      i_zero      = c.zero;
      i_neg       = c.neg;
      #2;
      checkOutput($sformatf("%s#%0d", c.tag, idx),
                  {o_ir, o_mem_req, o_mem_we, o_addr_sel, o_alu_op,
                   o_rf_we, o_wd_sel, o_pc_we, o_halted, o_fault}, c.exp);
      idx++;
    end
  endtask

  initial begin
    i_reset = 1'b1; i_run = 1'b0; i_mem_rdata = '0; i_mem_ack = 1'b0;
    i_neg = 1'b0; i_zero = 1'b0;
    expIr = '0;
    repeat (2) @(posedge i_clk);

    pushIdle(1'b0, 1'b0);
    pushIdle(1'b1, 1'b0);
    applyStimulus(16'h0123, 1, 0, 1'b0, 1'b0);
    applyStimulus(16'h8A52, 0, 1, 1'b0, 1'b0);
    applyStimulus(16'h9123, 1, 2, 1'b0, 1'b0);
    applyStimulus(16'h5ABC, 2, 0, 1'b0, 1'b0);
    applyStimulus(16'hA000, 0, 0, 1'b1, 1'b0);
    applyStimulus(16'hA001, 0, 0, 1'b0, 1'b1);
    applyStimulus(16'hB000, 1, 0, 1'b0, 1'b1);
    applyStimulus(16'hB002, 0, 0, 1'b1, 1'b0);
    applyStimulus(16'hC000, 0, 0, 1'b0, 1'b0);
    applyStimulus(16'hD000, 0, 0, 1'b1, 1'b1);
    applyStimulus(16'hF000, 0, 0, 1'b0, 1'b0);
    pushHalt(4, 2'd0);

    pushCyc("haltReset", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0,
            mkExp(expIr, 0, 0, 0, 4'd0, 0, 0, 0, 1, 2'd0));
    expIr = '0;
    pushIdle(1'b0, 1'b0);
    pushIdle(1'b1, 1'b0);
    applyStimulus(16'hE000, 0, 0, 1'b0, 1'b0);
    pushHalt(3, 2'd1);
    pushCyc("illReset", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0,
            mkExp(expIr, 0, 0, 0, 4'd0, 0, 0, 0, 1, 2'd1));
    expIr = '0;
    pushIdle(1'b0, 1'b0);

    // Reset while a load is waiting in MEM; the late ack must be ignored.
    pushIdle(1'b1, 1'b0);
    pushCyc("fetchAck", 1'b0, 1'b1, 1'b1, 16'h8111, 1'b0, 1'b0,
            mkExp(expIr, 1, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
    expIr = 16'h8111;
    pushCyc("decode", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0,
            mkExp(expIr, 0, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
    pushCyc("addr", 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0,
            mkExp(expIr, 0, 0, 0, 4'd8, 0, 0, 0, 0, 2'd0));
    pushCyc("memReset", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0,
            mkExp(expIr, 1, 0, 1, 4'd8, 0, 0, 0, 0, 2'd0));
    expIr = '0;
    pushIdle(1'b0, 1'b1);
    pushIdle(1'b0, 1'b0);

`ifdef ALBA_BUS_TIMEOUT_EN
    pushIdle(1'b1, 1'b0);
    for (int k = 0; k < TIMEOUT; k++)
      pushCyc("tmoWait", 1'b0, rnd1(), 1'b0, 16'($urandom), rnd1(), rnd1(),
              mkExp(expIr, 1, 0, 0, 4'd0, 0, 0, 0, 0, 2'd0));
    pushHalt(3, 2'd2);
`endif

    runScoreboard();
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
